// File: rtl/regs_pkg.sv
// Shared types and constants for the register-file write path.
package regs_pkg;

    localparam int REGS_DW  = 32;
    localparam int REGS_AW  = 3;
    localparam int REGS_NUM = 8;

    typedef struct packed {
        logic [REGS_AW-1:0] addr;
        logic [REGS_DW-1:0] data;
    } regs_wr_req_t;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } regs_gnt_e;

endpackage

// File: rtl/regs_wr_fifo.sv
// Small per-requester write FIFO; ready is derived from full only, so a
// full FIFO refuses a push even on a cycle where it is also popped.
module regs_wr_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     cr,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Two-requester round-robin write arbiter for the 8x32 register file.
// Optional REGS_ZERO_REG_EN suppresses writes to register 0.
module regs_wr_arbiter
    import regs_pkg::*;
#(
    parameter int DW         = REGS_DW,
    parameter int AW         = REGS_AW,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          cr,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          WE,
    output logic [AW-1:0] Addr_W,
    output logic [DW-1:0] Di,
    output logic          idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    regs_gnt_e         r_last_grant;
    logic              w_full0;
    logic              w_full1;
    logic              w_empty0;
    logic              w_empty1;
    logic              w_pop0;
    logic              w_pop1;
    logic [CW-1:0]     w_count0;
    logic [CW-1:0]     w_count1;
    logic [AW+DW-1:0]  w_head0;
    logic [AW+DW-1:0]  w_head1;
    logic [AW+DW-1:0]  w_head;
    logic [AW-1:0]     w_head_addr;
    logic [DW-1:0]     w_head_data;
    logic              w_wr_en;

    regs_wr_fifo #(.W(AW+DW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk     (clk),
        .cr      (cr),
        .i_push  (req0_valid),
        .i_data  ({req0_addr, req0_data}),
        .i_pop   (w_pop0),
        .o_data  (w_head0),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_count (w_count0)
    );

    regs_wr_fifo #(.W(AW+DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk     (clk),
        .cr      (cr),
        .i_push  (req1_valid),
        .i_data  ({req1_addr, req1_data}),
        .i_pop   (w_pop1),
        .o_data  (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_count (w_count1)
    );

    assign req0_ready = !w_full0;
    assign req1_ready = !w_full1;
    assign idle       = (w_count0 == '0) && (w_count1 == '0) && !WE;

    // Requester 0 pops when alone or when requester 1 had the previous tie.
    assign w_pop0      = !w_empty0 && (w_empty1 || r_last_grant == GNT_REQ1);
    assign w_pop1      = !w_empty1 && !w_pop0;
    assign w_head      = w_pop0 ? w_head0 : w_head1;
    assign w_head_addr = w_head[AW+DW-1:DW];
    assign w_head_data = w_head[DW-1:0];

    always_comb begin
        w_wr_en = 1'b1;
`ifdef REGS_ZERO_REG_EN
        w_wr_en = (w_head_addr != '0);
`endif
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_last_grant <= GNT_REQ1;
            WE           <= 1'b0;
            Addr_W       <= '0;
            Di           <= '0;
        end else begin
            if (!w_empty0 && !w_empty1) begin
                r_last_grant <= w_pop0 ? GNT_REQ0 : GNT_REQ1;
            end
            if (w_pop0 || w_pop1) begin
                WE     <= w_wr_en;
                Addr_W <= w_head_addr;
                Di     <= w_head_data;
            end else begin
                WE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Self-checking bench for regs_wr_arbiter: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_regs_wr_arbiter;
    import regs_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
`ifdef REGS_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          cr;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, Addr_W;
    logic [DW-1:0] req0_data, req1_data, Di;
    logic          WE, idle;

    regs_wr_arbiter #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .cr         (cr),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .WE         (WE),
        .Addr_W     (Addr_W),
        .Di         (Di),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    regs_wr_req_t  q0[$];
    regs_wr_req_t  q1[$];
    logic          mLast;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mDi;
    logic          preReady0, preReady1;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        logic          idl;
    } vec_t;

    vec_t tbl[11];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        mLast = 1'b1;
        mWe   = 1'b0;
        mAddr = '0;
        mDi   = '0;
    endtask

    // Reference: queues in, one write out per edge, round-robin on ties.
    task automatic modelEdge(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit           acc0, acc1;
        int           who;
        regs_wr_req_t e;
        acc0 = v0 && (q0.size() < DEPTH);
        acc1 = v1 && (q1.size() < DEPTH);
        who  = -1;
        if (q0.size() > 0 && q1.size() > 0) begin
            who   = mLast ? 0 : 1;
            mLast = (who == 1);
        end else if (q0.size() > 0) begin
            who = 0;
        end else if (q1.size() > 0) begin
            who = 1;
        end
        if (who >= 0) begin
            e     = (who == 0) ? q0.pop_front() : q1.pop_front();
            mWe   = ZERO_EN ? (e.addr != 0) : 1'b1;
            mAddr = e.addr;
            mDi   = e.data;
        end else begin
            mWe = 1'b0;
        end
        if (acc0) q0.push_back('{addr: a0, data: d0});
        if (acc1) q1.push_back('{addr: a1, data: d1});
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        preReady0 = req0_ready;
        preReady1 = req1_ready;
        checkOutput("req0_ready", preReady0, q0.size() < DEPTH);
        checkOutput("req1_ready", preReady1, q1.size() < DEPTH);
        @(posedge clk);
        modelEdge(v0, a0, d0, v1, a1, d1);
        @(negedge clk);
        checkOutput("WE", WE, mWe);
        checkOutput("Addr_W", Addr_W, mAddr);
        checkOutput("Di", Di, mDi);
        checkOutput("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !mWe);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " WE"}, WE, 1'b0);
        checkOutput({tag, " Addr_W"}, Addr_W, '0);
        checkOutput({tag, " Di"}, Di, '0);
        checkOutput({tag, " req0_ready"}, req0_ready, 1'b1);
        checkOutput({tag, " req1_ready"}, req1_ready, 1'b1);
        checkOutput({tag, " idle"}, idle, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 0, 32'h0,        0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0,            1, 1, 1, 3, 32'hDEADBEEF, 0};
        tbl[2]  = '{0, 0, 0,            0, 0, 0,            1, 1, 0, 3, 32'hDEADBEEF, 1};
        tbl[3]  = '{1, 1, 32'hA0000000, 1, 2, 32'hB0000000, 1, 1, 0, 3, 32'hDEADBEEF, 0};
        tbl[4]  = '{1, 1, 32'hA0000001, 1, 2, 32'hB0000001, 1, 1, 1, 1, 32'hA0000000, 0};
        tbl[5]  = '{1, 1, 32'hA0000002, 1, 2, 32'hB0000002, 1, 0, 1, 2, 32'hB0000000, 0};
        tbl[6]  = '{0, 0, 0,            1, 2, 32'hB0000002, 0, 1, 1, 1, 32'hA0000001, 0};
        tbl[7]  = '{0, 0, 0,            0, 0, 0,            1, 0, 1, 2, 32'hB0000001, 0};
        tbl[8]  = '{0, 0, 0,            0, 0, 0,            1, 1, 1, 1, 32'hA0000002, 0};
        tbl[9]  = '{0, 0, 0,            0, 0, 0,            1, 1, 1, 2, 32'hB0000002, 0};
        tbl[10] = '{0, 0, 0,            0, 0, 0,            1, 1, 0, 2, 32'hB0000002, 1};

        cr = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 32'h1234;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 32'h5678;
        modelReset();
        #12;
        checkResetState("reset");
        @(negedge clk);
        cr = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] directed table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            checkOutput($sformatf("tbl%0d r0", i), preReady0, tbl[i].r0);
            checkOutput($sformatf("tbl%0d r1", i), preReady1, tbl[i].r1);
            checkOutput($sformatf("tbl%0d WE", i), WE, tbl[i].we);
            checkOutput($sformatf("tbl%0d Addr_W", i), Addr_W, tbl[i].addr);
            checkOutput($sformatf("tbl%0d Di", i), Di, tbl[i].di);
            checkOutput($sformatf("tbl%0d idle", i), idle, tbl[i].idl);
        end

        $display("[TB] register 0 writes");
        applyStimulus(1, 0, 32'd5, 0, 0, 0);
        applyStimulus(1, 1, 32'd7, 0, 0, 0);
        checkOutput("zero WE", WE, ZERO_EN ? 1'b0 : 1'b1);
        checkOutput("zero Di", Di, 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("one WE", WE, 1'b1);
        checkOutput("one Addr_W", Addr_W, 3'd1);
        checkOutput("one Di", Di, 32'd7);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 3'd4, 32'hC0 + i, 1, 3'd5, (q1.size() < DEPTH) ? 32'hD0 + i : 32'hEE);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset mid-burst");
        applyStimulus(1, 3'd2, 32'h51, 1, 3'd3, 32'h61);
        applyStimulus(1, 3'd2, 32'h52, 1, 3'd3, 32'h62);
        #2;
        cr = 1'b0;
        #1;
        modelReset();
        checkResetState("midreset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cr = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 3'd6, 32'h11, 1, 3'd5, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post-reset first grant", Addr_W, 3'd6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post-reset second grant", Addr_W, 3'd5);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regs_wr_arbiter.md
Name: regs_wr_arbiter

Overview:
- Write-port arbiter for the 8x32 register file.
- Two independent requesters (e.g. pipeline writeback and a debug/loader path) each push write requests into a private FIFO.
- A round-robin scheduler drains the FIFOs, one write per cycle, onto the register file's single write port (WE, Addr_W, Di).
- The register file's read ports are untouched by this block.

Parameters:
- DW, 32, data width; matches the register width.
- AW, 3, register address width; 8 registers.
- FIFO_DEPTH, 2, entries per requester FIFO; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- cr  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 FIFO can accept an entry.
- req0_addr  in  AW  requester 0 target register.
- req0_data  in  DW  requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1.
- WE  out  1  write enable to the register file decoder enable.
- Addr_W  out  AW  write address to the register file.
- Di  out  DW  write data to the register file.
- idle  out  1  both FIFOs empty and WE low.

Behaviour:
- Clock and reset: one clock, clk; reset cr is asynchronous and active-low.
- Reset values, applied while cr=0:
  - WE=0, Addr_W=0, Di=0.
  - Both FIFOs empty, so req0_ready=req1_ready=1 and idle=1.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation: all queued entries are discarded, and no partial write occurs after cr falls.
- Push:
  - An entry is accepted on an edge where reqN_valid && reqN_ready.
  - reqN_ready = !fullN, combinational from the FIFO count only. No pass-through: a full FIFO is not ready even while popping in the same cycle.
- FIFO count:
  - Range 0..FIFO_DEPTH.
  - Push and pop on the same edge leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Scheduler: evaluated every edge from the registered FIFO state.
  - Only FIFO0 non-empty: pop 0.
  - Only FIFO1 non-empty: pop 1.
  - Both non-empty: pop the one not equal to last_grant, then update last_grant.
  - Neither non-empty: no pop; WE is registered to 0 and Addr_W/Di hold their previous values.
- Output register: a pop registers WE=1, Addr_W=entry.addr, Di=entry.data. WE is a single-cycle pulse per entry.
- Latency:
  - Entry accepted at edge k → earliest pop at edge k+1 → register file loads at edge k+2.
  - Throughput is one write per cycle sustained; each requester gets at least 1 of every 2 writes under contention.
- Ordering:
  - Per-requester order is preserved.
  - Same-address requests from both requesters commit in grant order; the later write wins.
- idle = empty0 && empty1 && !WE.

Optional Feature:
- Macro: REGS_ZERO_REG_EN.
- When defined, register 0 is hardwired:
  - Entries with addr==0 are accepted and popped normally, and consume the grant turn.
  - The output register loads WE=0 for that slot, so register 0 is never written.
- When undefined: address 0 is written like any other register.

Decomposition:
- Shared package regs_pkg holds:
  - constants REGS_DW=32, REGS_AW=3, REGS_NUM=8;
  - typedef regs_wr_req_t {addr[AW], data[DW]};
  - grant-select typedef with values GNT_REQ0 and GNT_REQ1.
- One sub-module, regs_wr_fifo:
  - parameterised by depth;
  - push/pop interface, full and empty flags, count;
  - instantiated twice.
- Arbiter FSM and output register stay in the top module.

Test Plan:
- Reset: hold cr=0 with both valids high → WE=0, Addr_W=0, Di=0, both readys=1, idle=1. Release → no write until entries are accepted.
- Single write: req0 addr=3, data=32'hDEADBEEF accepted at edge k → WE=1, Addr_W=3, Di=DEADBEEF during cycle k+1..k+2 only; idle returns to 1 afterwards.
- Contention: both requesters continuously push (req0 data A0,A1,A2; req1 data B0,B1,B2) → write sequence A0,B0,A1,B1,A2,B2 with WE high every cycle.
- Backpressure: req1_valid held high with no pops possible (FIFO0 saturated first, then FIFO1 fed 2 entries in 2 cycles) → req1_ready=0 after the 2nd accept. Accepts resume only after a pop; no entry is lost or duplicated.
- Reset mid-burst: cr pulsed low with 2 entries queued in each FIFO → WE=0 immediately (asynchronous), no queued data is ever written afterwards, last_grant returns to 1.
- With REGS_ZERO_REG_EN: writes to addr 0 (data 5) then addr 1 (data 7) → one WE-low slot, then WE=1, Addr_W=1, Di=7. Without the macro: two WE pulses.
